stride_vp_top: RTL and testbench



---
 rtl/stride_vp_pkg.sv | 31 +++
 rtl/stride_vp_train.sv | 40 ++++
 rtl/stride_vp_top.sv | 147 ++++++++++++++
 tb/tb_stride_vp_top.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/stride_vp_pkg.sv
// Shared types and helpers for the tagged stride value predictor.
package stride_vp_pkg;

  localparam int TAG_W  = 8;
  localparam int DATA_W = 32;
  localparam int CONF_W = 3;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CONF_W-1:0] conf_t;

  localparam conf_t conf_sat_c = '1;

  typedef struct packed {
    logic  valid;
    tag_t  tag;
    data_t last;
    data_t stride;
    conf_t conf;
  } entry_t;

  // Word-aligned PC: index sits just above the byte offset, tag just above the index.
  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int iw);
    return (pc >> 2) & ((32'd1 << iw) - 32'd1);
  endfunction

  function automatic tag_t pc_tag(input logic [31:0] pc, input int iw);
    return tag_t'(pc >> (iw + 2));
  endfunction

endpackage

// File: rtl/stride_vp_train.sv
// Single-lane combinational training step: base entry + committed value -> updated entry.
module stride_vp_train
  import stride_vp_pkg::*;
(
  input  entry_t base,
  input  tag_t   tag,
  input  data_t  actual,
  output entry_t upd,
  output logic   mispred
);

  logic  hit;
  data_t new_stride;

  assign hit        = base.valid && (base.tag == tag);
  assign new_stride = actual - base.last;

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    upd     = base;
    mispred = 1'b0;
    if (!hit) begin
      upd.valid  = 1'b1;
      upd.tag    = tag;
      upd.last   = actual;
      upd.stride = '0;
      upd.conf   = '0;
    end else begin
      if (new_stride == base.stride) begin
        upd.conf = (base.conf == conf_sat_c) ? base.conf : base.conf + conf_t'(1);
      end else begin
        upd.stride = new_stride;
        upd.conf   = '0;
      end
      upd.last = actual;
      mispred  = (base.conf == conf_sat_c) && ((base.last + base.stride) != actual);
    end
  end

endmodule

// File: rtl/stride_vp_top.sv
// Tagged stride value predictor: 1-cycle lookup, chained multi-lane training from commit.
module stride_vp_top
  import stride_vp_pkg::*;
#(
  parameter int P_STORAGE_SIZE = 1024,
  parameter int P_TAG_WIDTH    = TAG_W,
  parameter int P_DATA_WIDTH   = DATA_W,
  parameter int P_CONF_WIDTH   = CONF_W,
  parameter int P_NUM_PRED     = 2
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [P_NUM_PRED-1:0][31:0]             fw_pc_i,
  input  logic [P_NUM_PRED-1:0]                   fw_valid_i,
  output logic [P_NUM_PRED-1:0][31:0]             pred_pc_o,
  output logic [P_NUM_PRED-1:0][P_DATA_WIDTH-1:0] pred_result_o,
  output logic [P_NUM_PRED-1:0]                   pred_conf_o,
  output logic [P_NUM_PRED-1:0]                   pred_hit_o,
  output logic [P_NUM_PRED-1:0]                   pred_valid_o,
  input  logic [P_NUM_PRED-1:0][31:0]             fb_pc_i,
  input  logic [P_NUM_PRED-1:0][P_DATA_WIDTH-1:0] fb_actual_i,
  input  logic [P_NUM_PRED-1:0]                   fb_valid_i,
  output logic [31:0]                             stat_mispred_o
);

  localparam int P_INDEX_WIDTH = $clog2(P_STORAGE_SIZE);
  typedef logic [P_INDEX_WIDTH-1:0] idx_t;

  logic [P_STORAGE_SIZE-1:0] vld;
  logic [P_TAG_WIDTH-1:0]    tag_mem    [P_STORAGE_SIZE];
  logic [P_DATA_WIDTH-1:0]   last_mem   [P_STORAGE_SIZE];
  logic [P_DATA_WIDTH-1:0]   stride_mem [P_STORAGE_SIZE];
  logic [P_CONF_WIDTH-1:0]   conf_mem   [P_STORAGE_SIZE];

  idx_t   fw_idx [P_NUM_PRED];
  idx_t   fb_idx [P_NUM_PRED];
  tag_t   fw_tag [P_NUM_PRED];
  tag_t   fb_tag [P_NUM_PRED];
  entry_t fw_rd  [P_NUM_PRED];
  entry_t fb_rd  [P_NUM_PRED];
  entry_t new_arr[P_NUM_PRED];
  logic [P_NUM_PRED-1:0] mis_vec;
  logic [P_NUM_PRED-1:0] wr_en;

  always_comb begin
    for (int p = 0; p < P_NUM_PRED; p++) begin
      fw_idx[p] = idx_t'(pc_index(fw_pc_i[p], P_INDEX_WIDTH));
      fb_idx[p] = idx_t'(pc_index(fb_pc_i[p], P_INDEX_WIDTH));
      fw_tag[p] = pc_tag(fw_pc_i[p], P_INDEX_WIDTH);
      fb_tag[p] = pc_tag(fb_pc_i[p], P_INDEX_WIDTH);
      fw_rd[p]  = '{valid: vld[fw_idx[p]], tag: tag_mem[fw_idx[p]], last: last_mem[fw_idx[p]],
                    stride: stride_mem[fw_idx[p]], conf: conf_mem[fw_idx[p]]};
      fb_rd[p]  = '{valid: vld[fb_idx[p]], tag: tag_mem[fb_idx[p]], last: last_mem[fb_idx[p]],
                    stride: stride_mem[fb_idx[p]], conf: conf_mem[fb_idx[p]]};
    end
  end

  // Each lane's base is the result of the youngest older valid lane on the same index, else the table.
  for (genvar p = 0; p < P_NUM_PRED; p++) begin : g_lane
    entry_t base_e;
    entry_t new_e;
    logic   mis;

    if (p == 0) begin : g_base
      assign base_e = fb_rd[0];
    end else begin : g_base
      for (genvar q = 0; q < p; q++) begin : g_src
        entry_t prev;
        entry_t sel;
        if (q == 0) begin : g_first
          assign prev = fb_rd[p];
        end else begin : g_next
          assign prev = g_src[q-1].sel;
        end
        assign sel = (fb_valid_i[q] && (fb_idx[q] == fb_idx[p])) ? g_lane[q].new_e : prev;
      end
      assign base_e = g_src[p-1].sel;
    end

    stride_vp_train u_train (
      .base    (base_e),
      .tag     (fb_tag[p]),
      .actual  (fb_actual_i[p]),
      .upd     (new_e),
      .mispred (mis)
    );

    assign new_arr[p] = new_e;
    assign mis_vec[p] = fb_valid_i[p] && mis;
  end

  always_comb begin
    wr_en = fb_valid_i;
    for (int p = 0; p < P_NUM_PRED; p++) begin
      for (int q = p + 1; q < P_NUM_PRED; q++) begin
        if (fb_valid_i[q] && (fb_idx[q] == fb_idx[p])) wr_en[p] = 1'b0;
      end
    end
  end

  // NOTE: only valid bits are reset; the payload arrays are don't-care until their valid bit is set.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < P_NUM_PRED; p++) begin
      if (wr_en[p]) begin
        tag_mem[fb_idx[p]]    <= new_arr[p].tag;
        last_mem[fb_idx[p]]   <= new_arr[p].last;
        stride_mem[fb_idx[p]] <= new_arr[p].stride;
        conf_mem[fb_idx[p]]   <= new_arr[p].conf;
      end
    end
  end

  logic [2:0]  mis_cnt;
  logic [32:0] stat_sum;

  always_comb begin
    mis_cnt = '0;
    for (int p = 0; p < P_NUM_PRED; p++) mis_cnt = mis_cnt + 3'(mis_vec[p]);
    stat_sum = {1'b0, stat_mispred_o} + 33'(mis_cnt);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld            <= '0;
      pred_pc_o      <= '0;
      pred_result_o  <= '0;
      pred_conf_o    <= '0;
      pred_hit_o     <= '0;
      pred_valid_o   <= '0;
      stat_mispred_o <= '0;
    end else begin
      for (int p = 0; p < P_NUM_PRED; p++) begin
        if (wr_en[p]) vld[fb_idx[p]] <= new_arr[p].valid;
        pred_pc_o[p]     <= fw_pc_i[p];
        pred_valid_o[p]  <= fw_valid_i[p];
        pred_hit_o[p]    <= fw_valid_i[p] && fw_rd[p].valid && (fw_rd[p].tag == fw_tag[p]);
        pred_conf_o[p]   <= fw_valid_i[p] && fw_rd[p].valid && (fw_rd[p].tag == fw_tag[p])
                            && (fw_rd[p].conf == conf_sat_c);
        pred_result_o[p] <= (fw_rd[p].valid && (fw_rd[p].tag == fw_tag[p]))
                            ? fw_rd[p].last + fw_rd[p].stride : '0;
      end
      stat_mispred_o <= stat_sum[32] ? '1 : stat_sum[31:0];
    end
  end

endmodule

// File: tb/tb_stride_vp_top.sv
// Directed self-checking bench for stride_vp_top with two lanes.
module tb_stride_vp_top;

  localparam int NP = 2;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic [NP-1:0][31:0]  fw_pc_i;
  logic [NP-1:0]        fw_valid_i;
  logic [NP-1:0][31:0]  pred_pc_o;
  logic [NP-1:0][31:0]  pred_result_o;
  logic [NP-1:0]        pred_conf_o;
  logic [NP-1:0]        pred_hit_o;
  logic [NP-1:0]        pred_valid_o;
  logic [NP-1:0][31:0]  fb_pc_i;
  logic [NP-1:0][31:0]  fb_actual_i;
  logic [NP-1:0]        fb_valid_i;
  logic [31:0]          stat_mispred_o;

  int passed = 0;
  int total  = 0;

  stride_vp_top #(.P_NUM_PRED(NP)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .fw_pc_i        (fw_pc_i),
    .fw_valid_i     (fw_valid_i),
    .pred_pc_o      (pred_pc_o),
    .pred_result_o  (pred_result_o),
    .pred_conf_o    (pred_conf_o),
    .pred_hit_o     (pred_hit_o),
    .pred_valid_o   (pred_valid_o),
    .fb_pc_i        (fb_pc_i),
    .fb_actual_i    (fb_actual_i),
    .fb_valid_i     (fb_valid_i),
    .stat_mispred_o (stat_mispred_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle();
    fw_valid_i  = '0;
    fb_valid_i  = '0;
    fw_pc_i     = '0;
    fb_pc_i     = '0;
    fb_actual_i = '0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fb1(input logic [31:0] pc, input logic [31:0] val);
    idle();
    fb_pc_i[0] = pc; fb_actual_i[0] = val; fb_valid_i[0] = 1'b1;
    step();
  endtask

  task automatic lookup(input logic [31:0] pc);
    idle();
    fw_pc_i[0] = pc; fw_valid_i[0] = 1'b1;
    step();
  endtask

  initial begin
    idle();
    rst_ni = 1'b0;
    repeat (3) step();
    check("rst_valid",  32'(pred_valid_o), 32'd0);
    check("rst_hit",    32'(pred_hit_o),   32'd0);
    check("rst_conf",   32'(pred_conf_o),  32'd0);
    check("rst_result", pred_result_o[0],  32'd0);
    check("rst_pc",     pred_pc_o[0],      32'd0);
    check("rst_stat",   stat_mispred_o,    32'd0);
    rst_ni = 1'b1;
    step();

    // First lookup misses; unused lane stays invalid.
    lookup(32'h100);
    check("miss_valid", 32'(pred_valid_o), 32'b01);
    check("miss_hit",   32'(pred_hit_o[0]), 32'd0);
    check("miss_conf",  32'(pred_conf_o[0]), 32'd0);
    check("miss_pc",    pred_pc_o[0], 32'h100);

    // Stride 10 training: counter reaches 6 after 80, saturates after 90.
    for (int i = 1; i <= 8; i++) fb1(32'h100, 32'(10 * i));
    lookup(32'h100);
    check("s10_hit",     32'(pred_hit_o[0]), 32'd1);
    check("s10_res90",   pred_result_o[0], 32'd90);
    check("s10_conf_lo", 32'(pred_conf_o[0]), 32'd0);
    fb1(32'h100, 32'd90);
    lookup(32'h100);
    check("s10_res100",  pred_result_o[0], 32'd100);
    check("s10_conf_hi", 32'(pred_conf_o[0]), 32'd1);

    // Same-cycle chain on 0x200: 5 then 8, then 11 -> stride 3, counter 1.
    idle();
    fb_pc_i[0] = 32'h200; fb_actual_i[0] = 32'd5; fb_valid_i[0] = 1'b1;
    fb_pc_i[1] = 32'h200; fb_actual_i[1] = 32'd8; fb_valid_i[1] = 1'b1;
    step();
    fb1(32'h200, 32'd11);
    idle();
    fw_pc_i[0] = 32'h200; fw_valid_i[0] = 1'b1;
    fw_pc_i[1] = 32'h100; fw_valid_i[1] = 1'b1;
    step();
    check("chain_hit",  32'(pred_hit_o), 32'b11);
    check("chain_res",  pred_result_o[0], 32'd14);
    check("chain_conf", 32'(pred_conf_o), 32'b10);
    check("lane1_res",  pred_result_o[1], 32'd100);

    // Saturate 0x300 on stride 4 ending at 40, then mispredict with 50.
    for (int i = 2; i <= 10; i++) fb1(32'h300, 32'(4 * i));
    lookup(32'h300);
    check("s4_res",  pred_result_o[0], 32'd44);
    check("s4_conf", 32'(pred_conf_o[0]), 32'd1);
    fb1(32'h300, 32'd50);
    check("mis_stat1", stat_mispred_o, 32'd1);
    lookup(32'h300);
    check("mis_res",  pred_result_o[0], 32'd60);
    check("mis_conf", 32'(pred_conf_o[0]), 32'd0);

    // Lookup and feedback to the same entry in one cycle: lookup sees the old entry.
    idle();
    fw_pc_i[0] = 32'h300; fw_valid_i[0] = 1'b1;
    fb_pc_i[0] = 32'h300; fb_actual_i[0] = 32'd60; fb_valid_i[0] = 1'b1;
    step();
    check("rbw_res", pred_result_o[0], 32'd60);
    lookup(32'h300);
    check("rbw_after", pred_result_o[0], 32'd70);
    check("rbw_stat",  stat_mispred_o, 32'd1);

    // Aliasing: same index, different tag reallocates the entry.
    fb1(32'h400, 32'd7);
    lookup(32'h400);
    check("alias_hit0", 32'(pred_hit_o[0]), 32'd1);
    check("alias_res0", pred_result_o[0], 32'd7);
    fb1(32'h1400, 32'd9);
    lookup(32'h400);
    check("alias_old_miss", 32'(pred_hit_o[0]), 32'd0);
    lookup(32'h1400);
    check("alias_new_hit", 32'(pred_hit_o[0]), 32'd1);
    check("alias_new_res", pred_result_o[0], 32'd9);

    // Two lanes on saturated 0x100: lane 0 mispredicts, only lane 1's chained result is stored.
    idle();
    fb_pc_i[0] = 32'h100; fb_actual_i[0] = 32'd95; fb_valid_i[0] = 1'b1;
    fb_pc_i[1] = 32'h100; fb_actual_i[1] = 32'd90; fb_valid_i[1] = 1'b1;
    step();
    check("dual_stat", stat_mispred_o, 32'd2);
    lookup(32'h100);
    check("dual_res",  pred_result_o[0], 32'd85);
    check("dual_conf", 32'(pred_conf_o[0]), 32'd0);

    // Asynchronous reset mid-cycle clears outputs at once and forgets the table.
    lookup(32'h100);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_valid", 32'(pred_valid_o), 32'd0);
    check("arst_hit",   32'(pred_hit_o), 32'd0);
    check("arst_stat",  stat_mispred_o, 32'd0);
    step();
    rst_ni = 1'b1;
    idle();
    fw_pc_i[0] = 32'h100; fw_valid_i[0] = 1'b1;
    fw_pc_i[1] = 32'h300; fw_valid_i[1] = 1'b1;
    step();
    check("post_valid", 32'(pred_valid_o), 32'b11);
    check("post_hit",   32'(pred_hit_o), 32'b00);
    check("post_conf",  32'(pred_conf_o), 32'b00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
